// File: rtl/fir_pkg.sv
// Shared constants, types and write-FSM encoding for the FIR output frame collector.
package fir_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned ACC_W      = 32;
  localparam int unsigned FRAME_LEN  = 16;
  localparam int unsigned FRAC_SHIFT = 16;
  localparam int unsigned IDX_W      = $clog2(FRAME_LEN);

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  typedef logic [SAMPLE_W-1:0] sample_t;
  // Element k sits at bits [16k+15:16k]; k=0 is the oldest sample of the frame.
  typedef logic [FRAME_LEN-1:0][SAMPLE_W-1:0] frame_t;

  typedef enum logic {
    W_FILL = 1'b0,
    W_DROP = 1'b1
  } w_state_e;

endpackage

// File: rtl/fir_frame_collector_if.sv
// FIR sample input and frame hand-off bus; master = FIR/consumer side, slave = collector.
interface fir_frame_collector_if;
  import fir_pkg::*;

  logic signed [ACC_W-1:0] fir_d;
  logic                    fir_valid;
  frame_t                  frame_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overflow;

  modport master (
    output fir_d, fir_valid, frame_ready,
    input  frame_data, frame_valid, overflow
  );

  modport slave (
    input  fir_d, fir_valid, frame_ready,
    output frame_data, frame_valid, overflow
  );

endinterface

// File: rtl/fir_round_sat.sv
// Registered round-half-up, Q16 shift and 16-bit saturation of FIR accumulator samples.
// The sat pulse port exists only when FIR_FRAME_SAT_CNT_EN is defined.
module fir_round_sat
  import fir_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] in_d,
  output logic                    out_valid,
  output sample_t                 out_d
`ifdef FIR_FRAME_SAT_CNT_EN
  ,
  output logic                    sat
`endif
);

  localparam int unsigned T_W = ACC_W + 1;
  localparam logic signed [T_W-1:0] ROUND_BIAS = T_W'(1) << (FRAC_SHIFT - 1);

  logic signed [T_W-1:0] t;
  logic signed [T_W-1:0] y;
  logic                  pos_over;
  logic                  neg_hit;
  sample_t               y_sat;

  // One extra bit of headroom so the rounding bias can never wrap.
  always_comb begin
    t        = {in_d[ACC_W-1], in_d} + ROUND_BIAS;
    y        = t >>> FRAC_SHIFT;
    pos_over = y > T_W'(SAT_MAX);
    neg_hit  = y <= T_W'(SAT_MIN);
    y_sat    = pos_over ? SAT_MAX : (neg_hit ? SAT_MIN : y[SAMPLE_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_d     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_d <= y_sat;
    end
  end

`ifdef FIR_FRAME_SAT_CNT_EN
  // A result pinned at the negative rail is reported as saturated too.
  always_ff @(posedge clk) begin
    if (!rst) sat <= 1'b0;
    else      sat <= in_valid & (pos_over | neg_hit);
  end
`endif

endmodule

// File: rtl/fir_frame_collector.sv
// Collects rounded FIR samples into ping-pong frames for the FFT; overruns drop whole frames.
// Optional: define FIR_FRAME_SAT_CNT_EN to add the saturating sat_cnt output.
module fir_frame_collector
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fir_frame_collector_if.slave  bus
`ifdef FIR_FRAME_SAT_CNT_EN
  ,
  output logic [15:0]           sat_cnt
`endif
);

  logic       stage_v;
  sample_t    stage_d;
`ifdef FIR_FRAME_SAT_CNT_EN
  logic       stage_sat;
`endif

  fir_round_sat u_round_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.fir_valid),
    .in_d      (bus.fir_d),
    .out_valid (stage_v),
    .out_d     (stage_d)
`ifdef FIR_FRAME_SAT_CNT_EN
    ,
    .sat       (stage_sat)
`endif
  );

  w_state_e         state;
  w_state_e         state_nxt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             w_sel;
  logic             r_sel;
  logic [IDX_W-1:0] w_idx;
  frame_t           bank [2];

  logic rel;
  logic rel_w;
  logic blocked;
  logic last_idx;
  logic wr_en;
  logic drop;

  // A release of the bank being written frees it for this cycle's idx-0 write.
  always_comb begin
    rel      = full[r_sel] & bus.frame_ready;
    rel_w    = rel & (r_sel == w_sel);
    blocked  = full[w_sel] & ~rel_w;
    last_idx = (w_idx == IDX_W'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= W_FILL;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      W_FILL: if (stage_v && (w_idx == '0) && blocked) state_nxt = W_DROP;
      W_DROP: if (rel_w) state_nxt = W_FILL;
      default: state_nxt = W_FILL;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    drop  = 1'b0;
    case (state)
      W_FILL: begin
        if (stage_v) begin
          if ((w_idx == '0) && blocked) drop  = 1'b1;
          else                          wr_en = 1'b1;
        end
      end
      W_DROP: begin
        if (stage_v) begin
          if (rel_w) wr_en = 1'b1;
          else       drop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Release clears the read bank, completion marks the write bank; they never collide.
  always_comb begin
    full_nxt = full;
    if (rel)               full_nxt[r_sel] = 1'b0;
    if (wr_en && last_idx) full_nxt[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full         <= '0;
      w_sel        <= 1'b0;
      r_sel        <= 1'b0;
      w_idx        <= '0;
      bank[0]      <= '0;
      bank[1]      <= '0;
      bus.overflow <= 1'b0;
    end else begin
      full <= full_nxt;
      if (rel) r_sel <= ~r_sel;
      if (drop) bus.overflow <= 1'b1;
      if (wr_en) begin
        bank[w_sel][w_idx] <= stage_d;
        if (last_idx) begin
          w_sel <= ~w_sel;
          w_idx <= '0;
        end else begin
          w_idx <= w_idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.frame_valid = full[r_sel];
  assign bus.frame_data  = bank[r_sel];

`ifdef FIR_FRAME_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                               sat_cnt <= '0;
    else if (stage_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fir_frame_collector.sv
// Self-checking bench for fir_frame_collector: frame scoreboard plus rounding vector table.
module tb_fir_frame_collector;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_frame_collector_if bus ();
`ifdef FIR_FRAME_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  fir_frame_collector dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave)
`ifdef FIR_FRAME_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  typedef struct {
    logic [31:0] d;
    logic [15:0] e;
  } vec_t;

  vec_t   vecs [16];
  frame_t exp_q [$];
  frame_t cur;
  int     cur_idx;
  int     drop_n;
  int     cyc;
  int     last_cyc;
  int     acc_cyc;
  int     fv_cycles;
  int     n_chk;
  int     n_pass;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Drive one cycle; model the sample, compare any presented frame, then advance.
  task automatic step(input logic v, input logic [31:0] d, input logic [15:0] e, input logic rdy);
    bus.fir_valid   = v;
    bus.fir_d       = d;
    bus.frame_ready = rdy;
    if (v && rst) begin
      if (drop_n > 0) begin
        drop_n--;
      end else begin
        cur[IDX_W'(cur_idx)] = e;
        cur_idx++;
        if (cur_idx == FRAME_LEN) begin
          exp_q.push_back(cur);
          cur_idx  = 0;
          last_cyc = cyc;
        end
      end
    end
    if (rst && bus.frame_valid === 1'b1) begin
      fv_cycles++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_frame: got frame_valid=1 want 0, data %0h", bus.frame_data);
      end else begin
        check("frame_data", bus.frame_data, exp_q[0]);
        if (rdy) begin
          void'(exp_q.pop_front());
          acc_cyc = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    exp_q.delete();
    cur_idx = 0;
    drop_n  = 0;
    repeat (n) step(1'b0, 32'h0, 16'h0, 1'b1);
    rst = 1'b1;
  endtask

  task automatic send_ramp(input int n, input int base, input bit gap, input logic rdy);
    for (int k = 1; k <= n; k++) begin
      step(1'b1, 32'((base + k) << 16), 16'(base + k), rdy);
      if (gap) step(1'b0, 32'h0, 16'h0, rdy);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 16'h0, 1'b1);
    check("drain_done", 256'(exp_q.size()), 256'd0);
    repeat (2) step(1'b0, 32'h0, 16'h0, 1'b1);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; cur = '0; cur_idx = 0; drop_n = 0;
    last_cyc = 0; acc_cyc = 0; fv_cycles = 0;
    rst = 1'b0;
    bus.fir_valid = 1'b0; bus.fir_d = '0; bus.frame_ready = 1'b0;

    vecs[0]  = '{32'h0001_8000, 16'h0002};
    vecs[1]  = '{32'h0001_7FFF, 16'h0001};
    vecs[2]  = '{32'hFFFF_8000, 16'h0000};
    vecs[3]  = '{32'h7FFF_FFFF, 16'h7FFF};
    vecs[4]  = '{32'h8000_0000, 16'h8000};
    vecs[5]  = '{32'h0000_0000, 16'h0000};
    vecs[6]  = '{32'hFFFF_FFFF, 16'h0000};
    vecs[7]  = '{32'hFFFF_7FFF, 16'hFFFF};
    vecs[8]  = '{32'h7FFF_7FFF, 16'h7FFF};
    vecs[9]  = '{32'h7FFF_8000, 16'h7FFF};
    vecs[10] = '{32'h8000_8000, 16'h8001};
    vecs[11] = '{32'h0002_0000, 16'h0002};
    vecs[12] = '{32'hFFFE_0000, 16'hFFFE};
    vecs[13] = '{32'hFFFE_8000, 16'hFFFF};
    vecs[14] = '{32'h0123_4567, 16'h0123};
    vecs[15] = '{32'hFEDC_BA98, 16'hFEDD};

    do_reset(2);
    check("reset_frame_valid", 256'(bus.frame_valid), 256'd0);
    check("reset_overflow", 256'(bus.overflow), 256'd0);
    check("reset_frame_data", bus.frame_data, 256'd0);

    // Partial frame wiped by a mid-frame reset
    send_ramp(7, 100, 1'b0, 1'b1);
    do_reset(2);
    check("midreset_frame_valid", 256'(bus.frame_valid), 256'd0);
    check("midreset_overflow", 256'(bus.overflow), 256'd0);

    // Ramp frame: latency and single-cycle valid
    fv_cycles = 0;
    send_ramp(16, 0, 1'b0, 1'b1);
    drain();
    check("frame_latency", 256'(acc_cyc - last_cyc), 256'd2);
    check("frame_valid_cycles", 256'(fv_cycles), 256'd1);

    // Rounding / saturation table as one frame
    for (int i = 0; i < 16; i++) step(1'b1, vecs[i].d, vecs[i].e, 1'b1);
    drain();
`ifdef FIR_FRAME_SAT_CNT_EN
    check("sat_cnt", 256'(sat_cnt), 256'd3);
`endif

    // Gapped input, two frames
    fv_cycles = 0;
    send_ramp(16, 0, 1'b1, 1'b1);
    send_ramp(16, 0, 1'b1, 1'b1);
    drain();
    check("gapped_frames", 256'(fv_cycles), 256'd2);

    // Back-to-back frames with ready held high
    send_ramp(48, 0, 1'b0, 1'b1);
    drain();
    check("b2b_no_overflow", 256'(bus.overflow), 256'd0);

    // Release of the write bank in the same cycle as its idx-0 write
    send_ramp(32, 300, 1'b0, 1'b0);
    for (int k = 33; k <= 48; k++) step(1'b1, 32'((300 + k) << 16), 16'(300 + k), k > 33);
    drain();
    check("same_cycle_release_no_overflow", 256'(bus.overflow), 256'd0);

    // Overrun: two frames held, third dropped whole
    send_ramp(32, 400, 1'b0, 1'b0);
    drop_n = 16;
    send_ramp(16, 432, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 16'h0, 1'b0);
    check("overrun_overflow", 256'(bus.overflow), 256'd1);
    check("overrun_frame_held", 256'(bus.frame_valid), 256'd1);
    drain();
    check("overflow_sticky", 256'(bus.overflow), 256'd1);
    send_ramp(16, 500, 1'b0, 1'b1);
    drain();
    check("overflow_still_set", 256'(bus.overflow), 256'd1);

    do_reset(2);
    check("reset_clears_overflow", 256'(bus.overflow), 256'd0);
    check("reset_clears_valid", 256'(bus.frame_valid), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
